flow_tile_averager: RTL and testbench

Upstream neighbour of the optical-flow display stage. It takes the per-pixel flow stream (vx, vy) with pix_valid/HS/VS and generates pixel coordinates. It sums each VEC_BOX_WIDTH x VEC_BOX_WIDTH tile's flow and emits one averaged, sign-preserving vector per tile with its tile column and row. The display's per-tile vector store loads from this output instead of point-sampling the tile corner pixel.

---
 rtl/of_pkg.sv | 29 ++
 rtl/flow_tile_averager_if.sv | 34 +++
 rtl/flow_tile_averager_pixel_cord_gen.sv | 108 ++++++++++
 rtl/flow_tile_averager.sv | 148 ++++++++++++++
 tb/tb_flow_tile_averager.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/of_pkg.sv
// ============================================================================
// of_pkg : shared widths, tile geometry and FSM encoding for the flow path
// Rev 1.0
// ============================================================================
`default_nettype none

package of_pkg;

  localparam int OF_CALC_WIDTH = 12;
  localparam int X_CORD_WIDTH  = 11;
  localparam int Y_CORD_WIDTH  = 11;
  localparam int FRAME_WIDTH   = 1280;
  localparam int FRAME_HEIGHT  = 1040;
  localparam int VEC_BOX_WIDTH = 32;
  localparam int BOX_LOG2      = 5;
  localparam int TILE_COLS     = FRAME_WIDTH / VEC_BOX_WIDTH;
  localparam int TILE_ROWS     = FRAME_HEIGHT / VEC_BOX_WIDTH;
  localparam int ACC_WIDTH     = OF_CALC_WIDTH + 2 * BOX_LOG2;
  localparam int COL_WIDTH     = X_CORD_WIDTH - BOX_LOG2;
  localparam int ROW_WIDTH     = Y_CORD_WIDTH - BOX_LOG2;

  typedef enum logic [0:0] {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/flow_tile_averager_if.sv
// ============================================================================
// flow_tile_averager_if : per-pixel flow stream in, per-tile vectors out
// Rev 1.0
// ============================================================================
`default_nettype none

interface flow_tile_averager_if;
  import of_pkg::*;

  logic signed [OF_CALC_WIDTH-1:0] vx;
  logic signed [OF_CALC_WIDTH-1:0] vy;
  logic                            pix_valid;
  logic                            HS;
  logic                            VS;
  logic signed [OF_CALC_WIDTH-1:0] vec_x_avg;
  logic signed [OF_CALC_WIDTH-1:0] vec_y_avg;
  logic [COL_WIDTH-1:0]            vec_col;
  logic [ROW_WIDTH-1:0]            vec_row;
  logic                            vec_valid;
  logic                            frame_done;

  modport master (
    output vx, vy, pix_valid, HS, VS,
    input  vec_x_avg, vec_y_avg, vec_col, vec_row, vec_valid, frame_done
  );

  modport slave (
    input  vx, vy, pix_valid, HS, VS,
    output vec_x_avg, vec_y_avg, vec_col, vec_row, vec_valid, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/flow_tile_averager_pixel_cord_gen.sv
// ============================================================================
// pixel_cord_gen : sync edge detect, frame FSM and pixel x/y counters
// Rev 1.0
// ============================================================================
`default_nettype none

module pixel_cord_gen #(
  parameter int FRAME_WIDTH  = of_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = of_pkg::FRAME_HEIGHT
) (
  input  wire logic                            clk,
  input  wire logic                            rst_n,
  input  wire logic                            hs,
  input  wire logic                            vs,
  input  wire logic                            pix_valid,
  output logic [of_pkg::X_CORD_WIDTH-1:0]      x_pos,
  output logic [of_pkg::Y_CORD_WIDTH-1:0]      y_pos,
  output logic                                 accept
);
  import of_pkg::*;

  fsm_state_t              r_state;
  fsm_state_t              w_state_nxt;
  logic                    w_active;
  logic                    r_hs_d;
  logic                    r_vs_d;
  logic                    w_hs_rise;
  logic                    w_vs_rise;
  logic [X_CORD_WIDTH-1:0] r_x_cnt;
  logic [X_CORD_WIDTH-1:0] w_x_eff;
  logic [X_CORD_WIDTH-1:0] w_x_nxt;
  logic [Y_CORD_WIDTH-1:0] r_y_cnt;
  logic [Y_CORD_WIDTH-1:0] w_y_eff;
  logic                    r_line_seen;
  logic                    w_seen_eff;

  assign w_hs_rise = hs & ~r_hs_d;
  assign w_vs_rise = vs & ~r_vs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_VS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == WAIT_VS && w_vs_rise) begin
      w_state_nxt = ACTIVE;
    end
  end

  always_comb begin
    w_active = (r_state == ACTIVE);
  end

  // Sync clears apply before the pixel in the same cycle is placed.
  always_comb begin
    w_x_eff    = r_x_cnt;
    w_y_eff    = r_y_cnt;
    w_seen_eff = r_line_seen;
    if (w_vs_rise) begin
      w_x_eff    = '0;
      w_y_eff    = '0;
      w_seen_eff = 1'b0;
    end else if (w_hs_rise) begin
      w_x_eff = '0;
      if (r_line_seen) begin
        w_y_eff    = r_y_cnt + Y_CORD_WIDTH'(1);
        w_seen_eff = 1'b0;
      end
    end
  end

  always_comb begin
    accept = w_active && pix_valid
          && (w_x_eff < X_CORD_WIDTH'(FRAME_WIDTH))
          && (w_y_eff < Y_CORD_WIDTH'(FRAME_HEIGHT));
    w_x_nxt = w_x_eff;
    if (w_active && pix_valid && (w_x_eff != '1)) begin
      w_x_nxt = w_x_eff + X_CORD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_d      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_line_seen <= 1'b0;
    end else begin
      r_hs_d      <= hs;
      r_vs_d      <= vs;
      r_x_cnt     <= w_x_nxt;
      r_y_cnt     <= w_y_eff;
      r_line_seen <= w_seen_eff | accept;
    end
  end

  assign x_pos = w_x_eff;
  assign y_pos = w_y_eff;

endmodule

`default_nettype wire

// File: rtl/flow_tile_averager.sv
// ============================================================================
// flow_tile_averager : sums each square tile of flow and emits its average
// Rev 1.0
// ============================================================================
`default_nettype none

module flow_tile_averager #(
  parameter int FRAME_WIDTH  = of_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = of_pkg::FRAME_HEIGHT
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  flow_tile_averager_if.slave              bus,
  output logic [of_pkg::X_CORD_WIDTH-1:0]  x_cord,
  output logic [of_pkg::Y_CORD_WIDTH-1:0]  y_cord
);
  import of_pkg::*;

  localparam int c_tile_cols = FRAME_WIDTH / VEC_BOX_WIDTH;
  localparam int c_tile_rows = FRAME_HEIGHT / VEC_BOX_WIDTH;
  localparam int c_col_idx_w = (c_tile_cols > 1) ? $clog2(c_tile_cols) : 1;

  logic [X_CORD_WIDTH-1:0]  w_x_pos;
  logic [Y_CORD_WIDTH-1:0]  w_y_pos;
  logic                     w_accept;
  logic [BOX_LOG2-1:0]      w_tx;
  logic [BOX_LOG2-1:0]      w_ty;
  logic [COL_WIDTH-1:0]     w_col;
  logic [ROW_WIDTH-1:0]     w_row;
  logic [c_col_idx_w-1:0]   w_col_idx;
  logic                     w_tile_end_x;
  logic                     w_tile_end_y;

  logic signed [ACC_WIDTH-1:0] w_vx_ext;
  logic signed [ACC_WIDTH-1:0] w_vy_ext;
  logic signed [ACC_WIDTH-1:0] r_line_acc_x;
  logic signed [ACC_WIDTH-1:0] r_line_acc_y;
  logic signed [ACC_WIDTH-1:0] w_line_base_x;
  logic signed [ACC_WIDTH-1:0] w_line_base_y;
  logic signed [ACC_WIDTH-1:0] w_line_sum_x;
  logic signed [ACC_WIDTH-1:0] w_line_sum_y;
  logic signed [ACC_WIDTH-1:0] w_col_base_x;
  logic signed [ACC_WIDTH-1:0] w_col_base_y;
  logic signed [ACC_WIDTH-1:0] w_tile_sum_x;
  logic signed [ACC_WIDTH-1:0] w_tile_sum_y;
  logic signed [ACC_WIDTH-1:0] r_col_acc_x [0:c_tile_cols-1];
  logic signed [ACC_WIDTH-1:0] r_col_acc_y [0:c_tile_cols-1];

  logic signed [OF_CALC_WIDTH-1:0] r_vec_x_avg;
  logic signed [OF_CALC_WIDTH-1:0] r_vec_y_avg;
  logic [COL_WIDTH-1:0]            r_vec_col;
  logic [ROW_WIDTH-1:0]            r_vec_row;
  logic                            r_vec_valid;
  logic                            r_frame_done;
  logic [X_CORD_WIDTH-1:0]         r_x_cord;
  logic [Y_CORD_WIDTH-1:0]         r_y_cord;

  pixel_cord_gen #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT)
  ) u_cord_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .hs        (bus.HS),
    .vs        (bus.VS),
    .pix_valid (bus.pix_valid),
    .x_pos     (w_x_pos),
    .y_pos     (w_y_pos),
    .accept    (w_accept)
  );

  assign w_tx         = w_x_pos[BOX_LOG2-1:0];
  assign w_ty         = w_y_pos[BOX_LOG2-1:0];
  assign w_col        = w_x_pos[X_CORD_WIDTH-1:BOX_LOG2];
  assign w_row        = w_y_pos[Y_CORD_WIDTH-1:BOX_LOG2];
  assign w_col_idx    = w_col[c_col_idx_w-1:0];
  assign w_tile_end_x = &w_tx;
  assign w_tile_end_y = &w_ty;

  assign w_vx_ext = {{(ACC_WIDTH-OF_CALC_WIDTH){bus.vx[OF_CALC_WIDTH-1]}}, bus.vx};
  assign w_vy_ext = {{(ACC_WIDTH-OF_CALC_WIDTH){bus.vy[OF_CALC_WIDTH-1]}}, bus.vy};

  // First pixel of a tile line / first line of a tile start from zero.
  always_comb begin
    w_line_base_x = (w_tx == '0) ? '0 : r_line_acc_x;
    w_line_base_y = (w_tx == '0) ? '0 : r_line_acc_y;
    w_line_sum_x  = w_line_base_x + w_vx_ext;
    w_line_sum_y  = w_line_base_y + w_vy_ext;
    w_col_base_x  = (w_ty == '0) ? '0 : r_col_acc_x[w_col_idx];
    w_col_base_y  = (w_ty == '0) ? '0 : r_col_acc_y[w_col_idx];
    w_tile_sum_x  = w_col_base_x + w_line_sum_x;
    w_tile_sum_y  = w_col_base_y + w_line_sum_y;
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_tile_end_x) begin
      r_col_acc_x[w_col_idx] <= w_tile_sum_x;
      r_col_acc_y[w_col_idx] <= w_tile_sum_y;
    end
  end

  // ACC_WIDTH is exactly OF_CALC_WIDTH + 2*BOX_LOG2, so this slice is the
  // floor-rounded arithmetic shift with nothing lost above it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_acc_x <= '0;
      r_line_acc_y <= '0;
      r_vec_x_avg  <= '0;
      r_vec_y_avg  <= '0;
      r_vec_col    <= '0;
      r_vec_row    <= '0;
      r_vec_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_x_cord     <= '0;
      r_y_cord     <= '0;
    end else begin
      r_vec_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_accept) begin
        r_line_acc_x <= w_line_sum_x;
        r_line_acc_y <= w_line_sum_y;
        r_x_cord     <= w_x_pos;
        r_y_cord     <= w_y_pos;
        if (w_tile_end_x && w_tile_end_y) begin
          r_vec_valid  <= 1'b1;
          r_vec_x_avg  <= w_tile_sum_x[2*BOX_LOG2 +: OF_CALC_WIDTH];
          r_vec_y_avg  <= w_tile_sum_y[2*BOX_LOG2 +: OF_CALC_WIDTH];
          r_vec_col    <= w_col;
          r_vec_row    <= w_row;
          r_frame_done <= (w_col == COL_WIDTH'(c_tile_cols - 1))
                       && (w_row == ROW_WIDTH'(c_tile_rows - 1));
        end
      end
    end
  end

  assign bus.vec_x_avg  = r_vec_x_avg;
  assign bus.vec_y_avg  = r_vec_y_avg;
  assign bus.vec_col    = r_vec_col;
  assign bus.vec_row    = r_vec_row;
  assign bus.vec_valid  = r_vec_valid;
  assign bus.frame_done = r_frame_done;
  assign x_cord         = r_x_cord;
  assign y_cord         = r_y_cord;

endmodule

`default_nettype wire

// File: tb/tb_flow_tile_averager.sv
// ============================================================================
// tb_flow_tile_averager : directed frames on a 64x64 frame (2x2 tiles)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_flow_tile_averager;
  import of_pkg::*;

  localparam int FW = 64;
  localparam int FH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [X_CORD_WIDTH-1:0] x_cord;
  logic [Y_CORD_WIDTH-1:0] y_cord;

  flow_tile_averager_if bus();

  flow_tile_averager #(
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .x_cord (x_cord),
    .y_cord (y_cord)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ax;
    int ay;
    int col;
    int row;
    bit fd;
  } strobe_t;

  strobe_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;
  int fd_base  = 0;

  always @(negedge clk) begin
    if (bus.vec_valid) begin
      q.push_back('{ax: int'(bus.vec_x_avg), ay: int'(bus.vec_y_avg),
                    col: int'(bus.vec_col), row: int'(bus.vec_row),
                    fd: bus.frame_done});
    end
    if (bus.frame_done) fd_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: summary not reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int vx_of(input int mode, input int x);
    case (mode)
      0: return 100;
      1: return -1;
      2: return (x % 2 == 0) ? 1 : 0;
      3: return x % 32;
      4: return -2048;
      default: return 2047;
    endcase
  endfunction

  function automatic int vy_of(input int mode, input int x);
    case (mode)
      0: return -37;
      1: return 3;
      2: return (x % 2 == 0) ? -1 : 0;
      3: return -(x % 32);
      4: return 2047;
      default: return -2048;
    endcase
  endfunction

  task automatic drive_vs();
    bus.VS = 1'b1;
    tick();
    bus.VS = 1'b0;
    tick();
  endtask

  task automatic drive_line(input int mode, input int y, input bit coinc, input bit chk_first);
    if (!coinc) begin
      bus.HS = 1'b1;
      bus.pix_valid = 1'b0;
      tick();
      bus.HS = 1'b0;
      tick();
    end
    for (int x = 0; x < FW; x++) begin
      bus.HS        = coinc && (x == 0);
      bus.pix_valid = 1'b1;
      bus.vx        = OF_CALC_WIDTH'(vx_of(mode, x));
      bus.vy        = OF_CALC_WIDTH'(vy_of(mode, x));
      tick();
      if (chk_first && x == 0) begin
        chk("hs_with_pixel x_cord", int'(x_cord), 0);
        chk("hs_with_pixel y_cord", int'(y_cord), y);
      end
    end
    bus.HS        = 1'b0;
    bus.pix_valid = 1'b0;
    tick();
  endtask

  task automatic drive_lines(input int mode, input int y0, input int y1, input bit coinc);
    for (int y = y0; y <= y1; y++) begin
      drive_line(mode, y, coinc, coinc && (y < 2));
    end
  endtask

  task automatic run_frame(input int mode, input bit coinc);
    drive_vs();
    drive_lines(mode, 0, FH - 1, coinc);
  endtask

  task automatic check_frame(input string tag, input int ex, input int ey);
    repeat (3) tick();
    chk({tag, " strobe count"}, q.size(), 4);
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      chk({tag, " col"},        q[i].col, i % 2);
      chk({tag, " row"},        q[i].row, i / 2);
      chk({tag, " vec_x_avg"},  q[i].ax, ex);
      chk({tag, " vec_y_avg"},  q[i].ay, ey);
      chk({tag, " frame_done"}, int'(q[i].fd), (i == 3) ? 1 : 0);
    end
    chk({tag, " frame_done pulses"}, fd_cnt - fd_base, 1);
    chk({tag, " hold vec_x_avg"}, int'(bus.vec_x_avg), ex);
    chk({tag, " hold vec_col"},   int'(bus.vec_col), 1);
    chk({tag, " hold vec_row"},   int'(bus.vec_row), 1);
    chk({tag, " last x_cord"},    int'(x_cord), FW - 1);
    chk({tag, " last y_cord"},    int'(y_cord), FH - 1);
    q.delete();
    fd_base = fd_cnt;
  endtask

  initial begin
    bus.vx        = '0;
    bus.vy        = '0;
    bus.pix_valid = 1'b0;
    bus.HS        = 1'b0;
    bus.VS        = 1'b0;
    rst_n         = 1'b0;
    repeat (3) tick();

    chk("reset vec_valid",  int'(bus.vec_valid), 0);
    chk("reset frame_done", int'(bus.frame_done), 0);
    chk("reset vec_x_avg",  int'(bus.vec_x_avg), 0);
    chk("reset vec_col",    int'(bus.vec_col), 0);
    chk("reset x_cord",     int'(x_cord), 0);
    chk("reset y_cord",     int'(y_cord), 0);
    rst_n = 1'b1;
    tick();

    // Pixels before the first VS rise are ignored.
    drive_line(0, 0, 1'b0, 1'b0);
    chk("pre_vs x_cord",  int'(x_cord), 0);
    chk("pre_vs strobes", q.size(), 0);

    run_frame(0, 1'b0); check_frame("const",    100,   -37);
    run_frame(1, 1'b0); check_frame("minus1",   -1,    3);
    run_frame(2, 1'b0); check_frame("alt",      0,     -1);
    run_frame(3, 1'b0); check_frame("ramp",     15,    -16);
    run_frame(4, 1'b0); check_frame("extreme1", -2048, 2047);
    run_frame(5, 1'b1); check_frame("extreme2", 2047,  -2048);

    // Reset in the middle of the second tile row.
    drive_vs();
    drive_lines(0, 0, 39, 1'b0);
    chk("pre_reset strobes", q.size(), 2);
    q.delete();
    bus.HS = 1'b1;
    tick();
    bus.HS = 1'b0;
    for (int x = 0; x < 10; x++) begin
      bus.pix_valid = 1'b1;
      bus.vx        = OF_CALC_WIDTH'(vx_of(0, x));
      bus.vy        = OF_CALC_WIDTH'(vy_of(0, x));
      tick();
    end
    chk("pre_reset x_cord", int'(x_cord), 9);
    rst_n = 1'b0;
    #1;
    chk("mid_reset vec_x_avg", int'(bus.vec_x_avg), 0);
    chk("mid_reset vec_col",   int'(bus.vec_col), 0);
    chk("mid_reset x_cord",    int'(x_cord), 0);
    chk("mid_reset y_cord",    int'(y_cord), 0);
    bus.pix_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    drive_lines(0, 0, 39, 1'b0);
    chk("post_reset no_vs strobes", q.size(), 0);
    chk("post_reset no_vs x_cord",  int'(x_cord), 0);
    run_frame(0, 1'b0); check_frame("after_reset", 100, -37);

    // Second VS rise mid-frame discards the partial tile row.
    drive_vs();
    drive_lines(1, 0, 39, 1'b0);
    chk("partial strobes", q.size(), 2);
    q.delete();
    drive_vs();
    drive_line(0, 0, 1'b0, 1'b0);
    chk("vs_restart y_cord", int'(y_cord), 0);
    chk("vs_restart x_cord", int'(x_cord), FW - 1);
    drive_lines(0, 1, FH - 1, 1'b0);
    check_frame("vs_restart", 100, -37);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
